// File: rtl/pq_head_ctrl.sv
// Command sequencer in front of the priority-queue head cell: one command in flight, one response per request.
// Optional statistics outputs (stat_ops_o, stat_err_o, stat_hwm_o) are added when PQ_HEAD_CTRL_STATS_EN is defined.
module pq_head_ctrl #(
    parameter int DEPTH      = 8,
    parameter int TW         = 4,
    parameter int PW         = 4,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_op_i,
    input  logic [TW-1:0]                req_id_i,
    input  logic [PW-1:0]                req_prio_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [TW-1:0]                rsp_id_o,
    output logic [PW-1:0]                rsp_prio_o,
    output logic                         rsp_err_o,
    output logic                         arr_push_o,
    output logic                         arr_pop_o,
    output logic                         arr_drop_o,
    output logic [TW-1:0]                arr_id_o,
    output logic [PW-1:0]                arr_prio_o,
    input  logic                         arr_push_vld_i,
    input  logic                         arr_pop_vld_i,
    input  logic                         arr_drop_vld_i,
    input  logic [TW-1:0]                arr_pop_id_i,
    input  logic [PW-1:0]                arr_pop_prio_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
`ifdef PQ_HEAD_CTRL_STATS_EN
    ,
    output logic [15:0]                  stat_ops_o,
    output logic [15:0]                  stat_err_o,
    output logic [$clog2(DEPTH+1)-1:0]   stat_hwm_o
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_DROP = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT, ST_REJECT, ST_RESP, ST_SETTLE
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      op_reg;
    logic [TW-1:0]   id_reg;
    logic [PW-1:0]   prio_reg;
    logic            rej_reg;
    logic [7:0]      cnt_reg;
    logic [CW-1:0]   count_reg;
    logic [TW-1:0]   rsp_id_reg;
    logic [PW-1:0]   rsp_prio_reg;
    logic            rsp_err_reg;
    logic            ready_int;
    logic            req_bad;
    logic            ack_hit;
    logic            tmo_hit;
    logic            settle_done;

    assign count_o   = count_reg;
    assign full_o    = (count_reg == CW'(DEPTH));
    assign empty_o   = (count_reg == '0);
    assign rsp_id_o   = rsp_id_reg;
    assign rsp_prio_o = rsp_prio_reg;
    assign rsp_err_o  = rsp_err_reg;

    // Screen illegal commands here so the cell array never sees them.
    assign req_bad = (req_op_i == OP_RSV)
                   || ((req_op_i == OP_PUSH) && full_o)
                   || ((req_op_i != OP_PUSH) && empty_o)
                   || ((req_op_i != OP_POP) && (req_id_i == '0));

    assign ack_hit = ((op_reg == OP_PUSH) && arr_push_vld_i)
                   || ((op_reg == OP_POP)  && arr_pop_vld_i)
                   || ((op_reg == OP_DROP) && arr_drop_vld_i);

    // WAIT lasts TIMEOUT-1 cycles, so an unacked command answers TIMEOUT cycles after its pulse.
    assign tmo_hit     = (cnt_reg == 8'(TIMEOUT-2));
    assign settle_done = (cnt_reg == 8'(SETTLE_CYC-1));
    assign req_ready_o = ready_int & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        ready_int   = 1'b0;
        arr_push_o  = 1'b0;
        arr_pop_o   = 1'b0;
        arr_drop_o  = 1'b0;
        arr_id_o    = '0;
        arr_prio_o  = '0;
        rsp_valid_o = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (req_valid_i) state_next = req_bad ? ST_REJECT : ST_ISSUE;
            end
            ST_ISSUE: begin
                arr_push_o = (op_reg == OP_PUSH);
                arr_pop_o  = (op_reg == OP_POP);
                arr_drop_o = (op_reg == OP_DROP);
                arr_id_o   = id_reg;
                arr_prio_o = prio_reg;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                arr_id_o   = id_reg;
                arr_prio_o = prio_reg;
                if (ack_hit || tmo_hit) state_next = ST_RESP;
            end
            ST_REJECT: state_next = ST_RESP;
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = rej_reg ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_reg       <= '0;
            id_reg       <= '0;
            prio_reg     <= '0;
            rej_reg      <= 1'b0;
            cnt_reg      <= '0;
            count_reg    <= '0;
            rsp_id_reg   <= '0;
            rsp_prio_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_reg   <= req_op_i;
                        id_reg   <= req_id_i;
                        prio_reg <= req_prio_i;
                        rej_reg  <= req_bad;
                    end
                end
                ST_ISSUE: cnt_reg <= '0;
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    // An ack coinciding with timeout expiry still wins.
                    if (ack_hit) begin
                        rsp_err_reg <= 1'b0;
                        if (op_reg == OP_PUSH) begin
                            if (count_reg != CW'(DEPTH)) count_reg <= count_reg + CW'(1);
                            rsp_id_reg   <= id_reg;
                            rsp_prio_reg <= '0;
                        end else begin
                            if (count_reg != '0) count_reg <= count_reg - CW'(1);
                            rsp_id_reg   <= (op_reg == OP_POP) ? arr_pop_id_i : id_reg;
                            rsp_prio_reg <= (op_reg == OP_POP) ? arr_pop_prio_i : '0;
                        end
                    end else if (tmo_hit) begin
                        rsp_err_reg  <= 1'b1;
                        rsp_id_reg   <= (op_reg == OP_POP) ? '0 : id_reg;
                        rsp_prio_reg <= '0;
                    end
                end
                ST_REJECT: begin
                    rsp_err_reg  <= 1'b1;
                    rsp_id_reg   <= (op_reg == OP_POP) ? '0 : id_reg;
                    rsp_prio_reg <= '0;
                end
                ST_RESP: begin
                    if (rsp_ready_i) cnt_reg <= '0;
                end
                ST_SETTLE: cnt_reg <= cnt_reg + 8'd1;
                default: cnt_reg <= '0;
            endcase
        end
    end

`ifdef PQ_HEAD_CTRL_STATS_EN
    logic [15:0]   stat_ops_reg;
    logic [15:0]   stat_err_reg;
    logic [CW-1:0] stat_hwm_reg;
    logic          rsp_fire;

    assign rsp_fire   = (state_reg == ST_RESP) && rsp_ready_i;
    assign stat_ops_o = stat_ops_reg;
    assign stat_err_o = stat_err_reg;
    assign stat_hwm_o = stat_hwm_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_ops_reg <= '0;
            stat_err_reg <= '0;
            stat_hwm_reg <= '0;
        end else if (rsp_fire) begin
            if (!rsp_err_reg && (stat_ops_reg != 16'hFFFF)) stat_ops_reg <= stat_ops_reg + 16'd1;
            if (rsp_err_reg && (stat_err_reg != 16'hFFFF))  stat_err_reg <= stat_err_reg + 16'd1;
            if (count_reg > stat_hwm_reg) stat_hwm_reg <= count_reg;
        end
    end
`endif

endmodule

// File: tb/tb_pq_head_ctrl.sv
// Randomized self-checking bench for pq_head_ctrl; the bench also plays the cell array.
module tb_pq_head_ctrl;

    localparam int DEPTH      = 8;
    localparam int TW         = 4;
    localparam int PW         = 4;
    localparam int SETTLE_CYC = 2;
    localparam int TIMEOUT    = 8;
    localparam int CW         = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid, req_ready_o;
    logic [1:0]    req_op;
    logic [TW-1:0] req_id;
    logic [PW-1:0] req_prio;
    logic          rsp_valid_o, rsp_ready;
    logic [TW-1:0] rsp_id_o;
    logic [PW-1:0] rsp_prio_o;
    logic          rsp_err_o;
    logic          arr_push_o, arr_pop_o, arr_drop_o;
    logic [TW-1:0] arr_id_o;
    logic [PW-1:0] arr_prio_o;
    logic          arr_push_vld, arr_pop_vld, arr_drop_vld;
    logic [TW-1:0] arr_pop_id;
    logic [PW-1:0] arr_pop_prio;
    logic [CW-1:0] count_o;
    logic          full_o, empty_o;
`ifdef PQ_HEAD_CTRL_STATS_EN
    logic [15:0]   stat_ops_o, stat_err_o;
    logic [CW-1:0] stat_hwm_o;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int n_txn    = 0;

    // Contents of the emulated cell array (acked operations only).
    logic [TW-1:0] q_id[$];
    logic [PW-1:0] q_prio[$];

    always #5 clk = ~clk;

    pq_head_ctrl #(.DEPTH(DEPTH), .TW(TW), .PW(PW), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_op_i(req_op),
        .req_id_i(req_id), .req_prio_i(req_prio),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id_o),
        .rsp_prio_o(rsp_prio_o), .rsp_err_o(rsp_err_o),
        .arr_push_o(arr_push_o), .arr_pop_o(arr_pop_o), .arr_drop_o(arr_drop_o),
        .arr_id_o(arr_id_o), .arr_prio_o(arr_prio_o),
        .arr_push_vld_i(arr_push_vld), .arr_pop_vld_i(arr_pop_vld), .arr_drop_vld_i(arr_drop_vld),
        .arr_pop_id_i(arr_pop_id), .arr_pop_prio_i(arr_pop_prio),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
`ifdef PQ_HEAD_CTRL_STATS_EN
        , .stat_ops_o(stat_ops_o), .stat_err_o(stat_err_o), .stat_hwm_o(stat_hwm_o)
`endif
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int pop_index();
        int best = 0;
        for (int i = 1; i < q_prio.size(); i++)
            if (q_prio[i] > q_prio[best]) best = i;
        return best;
    endfunction

    function automatic int find_id(input logic [TW-1:0] id);
        for (int i = 0; i < q_id.size(); i++)
            if (q_id[i] == id) return i;
        return -1;
    endfunction

    task automatic check_occupancy();
        chk_val("count", 32'(count_o), q_id.size());
        chk_val("full", 32'(full_o), 32'(q_id.size() == DEPTH));
        chk_val("empty", 32'(empty_o), 32'(q_id.size() == 0));
    endtask

    // One full request: delay = cycles from pulse to ack (0 = never), hold = cycles rsp_ready stays low.
    // Must be entered at a negedge with the controller idle; returns at a negedge with it idle again.
    task automatic do_req(input logic [1:0] op, input logic [TW-1:0] id, input logic [PW-1:0] prio,
                          input int delay, input int hold);
        bit            exp_rej, ok, chk_id;
        int            idx, drv_delay, exp_lat, npulse, pulse_cyc, rsp_cyc, gap;
        logic [1:0]    pulse_op;
        logic [TW-1:0] pulse_id, exp_id;
        logic [PW-1:0] pulse_prio, exp_prio;

        exp_rej = (op == 2'b11) || (op == 2'b00 && q_id.size() == DEPTH)
                || (op != 2'b00 && q_id.size() == 0) || (op != 2'b01 && id == '0);
        idx = -1;
        if (op == 2'b01 && q_id.size() > 0) idx = pop_index();
        if (op == 2'b10) idx = find_id(id);
        drv_delay = (op == 2'b10 && idx < 0) ? 0 : delay;
        ok      = !exp_rej && drv_delay >= 1 && drv_delay <= TIMEOUT-1;
        exp_lat = exp_rej ? 2 : (ok ? drv_delay + 2 : TIMEOUT + 1);
        exp_id   = id;
        exp_prio = '0;
        if (op == 2'b01 && ok) begin
            exp_id   = q_id[idx];
            exp_prio = q_prio[idx];
        end
        chk_id = (op == 2'b00) || (op == 2'b10) || (op == 2'b01 && ok);

        req_valid = 1'b1; req_op = op; req_id = id; req_prio = prio;
        chk_val("req_ready_idle", 32'(req_ready_o), 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'($urandom); req_id = TW'($urandom); req_prio = PW'($urandom);

        npulse = 0; pulse_cyc = -1; rsp_cyc = -1;
        pulse_op = '0; pulse_id = '0; pulse_prio = '0;
        for (int k = 1; k <= TIMEOUT + 6 && rsp_cyc < 0; k++) begin
            @(negedge clk);
            npulse += int'(arr_push_o) + int'(arr_pop_o) + int'(arr_drop_o);
            if ((arr_push_o || arr_pop_o || arr_drop_o) && pulse_cyc < 0) begin
                pulse_cyc  = k;
                pulse_op   = arr_pop_o ? 2'b01 : (arr_drop_o ? 2'b10 : 2'b00);
                pulse_id   = arr_id_o;
                pulse_prio = arr_prio_o;
            end
            if (rsp_valid_o) rsp_cyc = k;
            else chk_val("busy_ready", 32'(req_ready_o), 0);
            // Noise on the acknowledges that do not belong to this op; they must be ignored.
            arr_push_vld = (op != 2'b00) && ($urandom_range(0, 1) == 1);
            arr_pop_vld  = (op != 2'b01) && ($urandom_range(0, 1) == 1);
            arr_drop_vld = (op != 2'b10) && ($urandom_range(0, 1) == 1);
            arr_pop_id   = TW'($urandom);
            arr_pop_prio = PW'($urandom);
            if (drv_delay > 0 && k == drv_delay + 1) begin
                case (op)
                    2'b00: arr_push_vld = 1'b1;
                    2'b01: begin
                        arr_pop_vld = 1'b1;
                        if (idx >= 0) begin
                            arr_pop_id   = q_id[idx];
                            arr_pop_prio = q_prio[idx];
                        end
                    end
                    2'b10: arr_drop_vld = 1'b1;
                    default: ;
                endcase
            end
        end
        arr_push_vld = 1'b0; arr_pop_vld = 1'b0; arr_drop_vld = 1'b0;

        chk_val("rsp_latency", rsp_cyc, exp_lat);
        chk_val("pulse_count", npulse, exp_rej ? 0 : 1);
        if (!exp_rej) begin
            chk_val("pulse_cycle", pulse_cyc, 1);
            chk_val("pulse_op", 32'(pulse_op), 32'(op));
            if (op != 2'b01) chk_val("arr_id", 32'(pulse_id), 32'(id));
            if (op == 2'b00) chk_val("arr_prio", 32'(pulse_prio), 32'(prio));
        end
        chk_val("rsp_err", 32'(rsp_err_o), 32'(!ok));
        if (chk_id) chk_val("rsp_id", 32'(rsp_id_o), 32'(exp_id));
        chk_val("rsp_prio", 32'(rsp_prio_o), 32'(exp_prio));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk_val("hold_valid", 32'(rsp_valid_o), 1);
            chk_val("hold_err", 32'(rsp_err_o), 32'(!ok));
            if (chk_id) chk_val("hold_id", 32'(rsp_id_o), 32'(exp_id));
            chk_val("hold_prio", 32'(rsp_prio_o), 32'(exp_prio));
            chk_val("hold_ready", 32'(req_ready_o), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        gap = exp_rej ? 0 : SETTLE_CYC;
        for (int s = 0; s < gap; s++) begin
            @(negedge clk);
            chk_val("settle_ready", 32'(req_ready_o), 0);
            chk_val("settle_rsp", 32'(rsp_valid_o), 0);
        end
        @(negedge clk);
        chk_val("idle_ready", 32'(req_ready_o), 1);

        if (ok) begin
            case (op)
                2'b00: begin q_id.push_back(id); q_prio.push_back(prio); end
                default: begin q_id.delete(idx); q_prio.delete(idx); end
            endcase
        end
        check_occupancy();
        n_txn++;
        $display("txn %0d: op=%0d id=%0d prio=%0d delay=%0d hold=%0d -> err=%0d rsp_id=%0d rsp_prio=%0d count=%0d",
                 n_txn, op, id, prio, drv_delay, hold, rsp_err_o, rsp_id_o, rsp_prio_o, count_o);
    endtask

    initial begin
        logic [1:0]    r_op;
        logic [TW-1:0] r_id;
        int            sel;

        rst_i = 1'b1; req_valid = 1'b0; req_op = '0; req_id = '0; req_prio = '0; rsp_ready = 1'b0;
        arr_push_vld = 1'b0; arr_pop_vld = 1'b0; arr_drop_vld = 1'b0; arr_pop_id = '0; arr_pop_prio = '0;
        repeat (2) @(negedge clk);
        chk_val("rst_req_ready", 32'(req_ready_o), 0);
        chk_val("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk_val("rst_arr_pulse", 32'({arr_push_o, arr_pop_o, arr_drop_o}), 0);
        chk_val("rst_count", 32'(count_o), 0);
        chk_val("rst_empty", 32'(empty_o), 1);
        chk_val("rst_full", 32'(full_o), 0);
        rst_i = 1'b0;
        @(negedge clk);

        do_req(2'b01, 4'd0, 4'd0, 1, 0);       // pop while empty
        do_req(2'b00, 4'd3, 4'd5, 1, 0);       // best-case push
        do_req(2'b00, 4'd4, 4'd6, 2, 5);       // slow consumer

        // Reset while waiting for the array: outputs clear at once, nothing stale afterwards.
        req_valid = 1'b1; req_op = 2'b00; req_id = 4'd5; req_prio = 4'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_val("wait_arr_id", 32'(arr_id_o), 5);
        rst_i = 1'b1;
        #1;
        chk_val("mid_rst_ready", 32'(req_ready_o), 0);
        chk_val("mid_rst_rsp", 32'(rsp_valid_o), 0);
        chk_val("mid_rst_arr", 32'({arr_push_o, arr_pop_o, arr_drop_o}), 0);
        chk_val("mid_rst_arr_id", 32'(arr_id_o), 0);
        chk_val("mid_rst_count", 32'(count_o), 0);
        chk_val("mid_rst_empty", 32'(empty_o), 1);
        q_id.delete(); q_prio.delete();
        @(negedge clk);
        rst_i = 1'b0;
        arr_push_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            arr_push_vld = 1'b0;
            chk_val("post_rst_rsp", 32'(rsp_valid_o), 0);
            chk_val("post_rst_ready", 32'(req_ready_o), 1);
        end
        check_occupancy();

        for (int i = 1; i <= DEPTH; i++)
            do_req(2'b00, TW'(i), (i == 7) ? 4'd2 : 4'd1, 1 + i % 3, 0);
        chk_val("full_flag", 32'(full_o), 1);
        do_req(2'b00, 4'd9, 4'd3, 1, 0);       // push while full
        do_req(2'b01, 4'd0, 4'd0, 2, 1);       // pop returns id 7 prio 2
        do_req(2'b10, 4'd9, 4'd0, 1, 0);       // drop of absent id times out

        for (int t = 0; t < 250; t++) begin
            sel  = $urandom_range(0, 9);
            r_op = (sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
            r_id = TW'($urandom);
            if (r_op == 2'b10 && q_id.size() > 0 && $urandom_range(0, 3) != 0)
                r_id = q_id[$urandom_range(0, q_id.size() - 1)];
            do_req(r_op, r_id, PW'($urandom), $urandom_range(0, TIMEOUT + 1),
                   ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
